// File: rtl/mips_pkg.sv
// Shared pipeline-control types and constants.
package mips_pkg;

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    HALT     = 2'd3
  } pipe_state_t;

  localparam logic [4:0] REG_ZERO    = 5'd0;
  localparam int         STALL_CNT_W = 16;

  // Control outputs grouped so each FSM case can start from a preset.
  typedef struct packed {
    logic pc_en;
    logic en_if_id;
    logic en_id_ex;
    logic en_ex_mem;
    logic en_mem_wb;
    logic flush_if_id;
    logic flush_id_ex;
    logic bubble_mem_wb;
    logic dmem_req;
  } pipe_ctrl_t;

  // Free-running pipeline: every register loads, nothing squashed.
  localparam pipe_ctrl_t CTRL_ALL_EN = '{
    pc_en: 1'b1, en_if_id: 1'b1, en_id_ex: 1'b1, en_ex_mem: 1'b1,
    en_mem_wb: 1'b1, flush_if_id: 1'b0, flush_id_ex: 1'b0,
    bubble_mem_wb: 1'b0, dmem_req: 1'b0};

  // Memory stall: front end frozen, MEM/WB keeps draining bubbles.
  localparam pipe_ctrl_t CTRL_MEM_STALL = '{
    pc_en: 1'b0, en_if_id: 1'b0, en_id_ex: 1'b0, en_ex_mem: 1'b0,
    en_mem_wb: 1'b1, flush_if_id: 1'b0, flush_id_ex: 1'b0,
    bubble_mem_wb: 1'b1, dmem_req: 1'b1};

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: the load in EX writes a register the instruction in ID reads.
module hazard_detect
  import mips_pkg::*;
(
  input  logic       ex_mem_read,
  input  logic [4:0] ex_write_reg,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  output logic       load_use
);

  // $0 is hardwired to zero, so a load targeting it never creates a dependency.
  always_comb begin
    load_use = ex_mem_read && (ex_write_reg != REG_ZERO) &&
               ((ex_write_reg == id_rs) || (id_uses_rt && (ex_write_reg == id_rt)));
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken branch,
// multi-cycle data memory with timeout, and a saturating stall counter.
module pipe_ctrl
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_write_reg,
  input  logic        ex_branch_taken,
  input  logic        mem_access,
  input  logic        dmem_ready,
  output logic        pc_en,
  output logic        en_if_id,
  output logic        en_id_ex,
  output logic        en_ex_mem,
  output logic        en_mem_wb,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        bubble_mem_wb,
  output logic        dmem_req,
  output logic [15:0] stall_cnt,
  output logic        err_timeout
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  pipe_state_t            state_q, state_d;
  logic [7:0]             wait_cnt_q, wait_cnt_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic                   err_timeout_q, err_timeout_d;
  pipe_ctrl_t             ctrl;
  logic                   load_use;

  hazard_detect u_hazard (
    .ex_mem_read  (ex_mem_read),
    .ex_write_reg (ex_write_reg),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .load_use     (load_use)
  );

  // Next state and combinational controls; priority is memory > branch > load-use.
  always_comb begin
    ctrl          = '0;
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    err_timeout_d = err_timeout_q;
    case (state_q)
      INIT: state_d = RUN;
      RUN: begin
        if (mem_access && !dmem_ready) begin
          ctrl       = CTRL_MEM_STALL;
          state_d    = MEM_WAIT;
          wait_cnt_d = 8'd1;
        end else begin
          ctrl          = CTRL_ALL_EN;
          ctrl.dmem_req = mem_access;
          if (ex_branch_taken) begin
            ctrl.flush_if_id = 1'b1;
            ctrl.flush_id_ex = 1'b1;
          end else if (load_use) begin
            // ID/EX stays enabled so the bubble actually gets loaded.
            ctrl.pc_en       = 1'b0;
            ctrl.en_if_id    = 1'b0;
            ctrl.flush_id_ex = 1'b1;
          end
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          // Release cycle: load-use is not re-checked, a taken branch still flushes.
          ctrl             = CTRL_ALL_EN;
          ctrl.dmem_req    = 1'b1;
          ctrl.flush_if_id = ex_branch_taken;
          ctrl.flush_id_ex = ex_branch_taken;
          state_d          = RUN;
          wait_cnt_d       = 8'd0;
        end else begin
          ctrl = CTRL_MEM_STALL;
          if (wait_cnt_q >= TIMEOUT_CNT) begin
            state_d       = HALT;
            err_timeout_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end
      end
      HALT: ctrl = '0;
      default: state_d = INIT;
    endcase

    stall_cnt_d = stall_cnt_q;
    if ((state_q != INIT) && !ctrl.pc_en && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  // State, wait counter, perf counter and sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= INIT;
      wait_cnt_q    <= '0;
      stall_cnt_q   <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign pc_en         = ctrl.pc_en;
  assign en_if_id      = ctrl.en_if_id;
  assign en_id_ex      = ctrl.en_id_ex;
  assign en_ex_mem     = ctrl.en_ex_mem;
  assign en_mem_wb     = ctrl.en_mem_wb;
  assign flush_if_id   = ctrl.flush_if_id;
  assign flush_id_ex   = ctrl.flush_id_ex;
  assign bubble_mem_wb = ctrl.bubble_mem_wb;
  assign dmem_req      = ctrl.dmem_req;
  assign stall_cnt     = stall_cnt_q;
  assign err_timeout   = err_timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: RUN-state vector table plus multi-cycle sequences.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_write_reg;
  logic        id_uses_rt, ex_mem_read, ex_branch_taken, mem_access, dmem_ready;
  logic        pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
  logic        flush_if_id, flush_id_ex, bubble_mem_wb, dmem_req;
  logic [15:0] stall_cnt;
  logic        err_timeout;
  logic [8:0]  outs;

  int checks = 0;
  int errors = 0;
  int exp_stall;

  // {pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb, flush_if_id, flush_id_ex, bubble, req}
  localparam logic [8:0] O_IDLE   = 9'b1_1111_00_0_0;
  localparam logic [8:0] O_LU     = 9'b0_0111_01_0_0;
  localparam logic [8:0] O_BR     = 9'b1_1111_11_0_0;
  localparam logic [8:0] O_STALL  = 9'b0_0001_00_1_1;
  localparam logic [8:0] O_REL    = 9'b1_1111_00_0_1;
  localparam logic [8:0] O_REL_BR = 9'b1_1111_11_0_1;
  localparam logic [8:0] O_ZERO   = 9'b0;

  pipe_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_write_reg(ex_write_reg),
    .ex_branch_taken(ex_branch_taken), .mem_access(mem_access), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .en_if_id(en_if_id), .en_id_ex(en_id_ex), .en_ex_mem(en_ex_mem),
    .en_mem_wb(en_mem_wb), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .bubble_mem_wb(bubble_mem_wb), .dmem_req(dmem_req), .stall_cnt(stall_cnt),
    .err_timeout(err_timeout)
  );

  assign outs = {pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
                 flush_if_id, flush_id_ex, bubble_mem_wb, dmem_req};

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [4:0] rs, rt;
    logic       urt, mr;
    logic [4:0] wr;
    logic       br, ma, rdy;
    logic [8:0] exp;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
    ex_write_reg = 5'd0; ex_branch_taken = 1'b0; mem_access = 1'b0; dmem_ready = 1'b0;
  endtask

  // Leaves the caller at a negedge with the DUT in its first RUN cycle.
  task automatic do_reset();
    @(negedge clk); rst = 1'b0; idle();
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    vt[0] = '{"idle",          5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_IDLE};
    vt[1] = '{"lu_rs",         5'd5, 5'd9, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, O_LU};
    vt[2] = '{"lu_rt",         5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, O_LU};
    vt[3] = '{"rt_unused",     5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, O_IDLE};
    vt[4] = '{"reg_zero",      5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, O_IDLE};
    vt[5] = '{"not_load",      5'd6, 5'd6, 1'b1, 1'b0, 5'd6, 1'b0, 1'b0, 1'b0, O_IDLE};
    vt[6] = '{"branch_over_lu",5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, O_BR};
    vt[7] = '{"branch",        5'd1, 5'd2, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, O_BR};
    vt[8] = '{"mem_fast",      5'd1, 5'd2, 1'b1, 1'b0, 5'd4, 1'b0, 1'b1, 1'b1, O_REL};
    vt[9] = '{"mem_fast_lu",   5'd8, 5'd2, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1, 1'b1, 9'b0_0111_01_0_1};

    // Reset with random inputs: everything at zero.
    rst = 1'b0; idle();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      id_rs = 5'($urandom); id_rt = 5'($urandom); id_uses_rt = 1'($urandom);
      ex_mem_read = 1'($urandom); ex_write_reg = 5'($urandom);
      ex_branch_taken = 1'($urandom); mem_access = 1'($urandom); dmem_ready = 1'($urandom);
      #1;
      chk("rst_outs", 32'(outs), 32'(O_ZERO));
      chk("rst_stall", 32'(stall_cnt), 32'd0);
      chk("rst_err", 32'(err_timeout), 32'd0);
    end
    @(negedge clk); idle(); rst = 1'b1; #1;
    chk("init_outs", 32'(outs), 32'(O_ZERO));
    @(negedge clk); #1;
    chk("run_idle", 32'(outs), 32'(O_IDLE));
    chk("run_stall0", 32'(stall_cnt), 32'd0);

    // RUN-state table; stall_cnt tracked from the expected pc_en of each vector.
    exp_stall = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      id_rs = vt[i].rs; id_rt = vt[i].rt; id_uses_rt = vt[i].urt; ex_mem_read = vt[i].mr;
      ex_write_reg = vt[i].wr; ex_branch_taken = vt[i].br;
      mem_access = vt[i].ma; dmem_ready = vt[i].rdy;
      #1;
      chk(vt[i].nm, 32'(outs), 32'(vt[i].exp));
      chk({vt[i].nm, "_cnt"}, 32'(stall_cnt), 32'(exp_stall));
      if (!vt[i].exp[8]) exp_stall++;
    end
    @(negedge clk); idle(); #1;
    chk("table_cnt", 32'(stall_cnt), 32'(exp_stall));

    // Memory wait: 3 MEM_WAIT cycles with ready low, answered in the 4th.
    do_reset();
    mem_access = 1'b1; dmem_ready = 1'b0; #1;
    chk("mem_detect", 32'(outs), 32'(O_STALL));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("mem_wait", 32'(outs), 32'(O_STALL));
    end
    @(negedge clk);
    dmem_ready = 1'b1; ex_mem_read = 1'b1; ex_write_reg = 5'd3; id_rs = 5'd3; #1;
    chk("mem_release", 32'(outs), 32'(O_REL));
    chk("mem_cnt", 32'(stall_cnt), 32'd4);
    @(negedge clk); idle(); #1;
    chk("mem_after", 32'(outs), 32'(O_IDLE));
    chk("mem_cnt_after", 32'(stall_cnt), 32'd4);
    @(negedge clk); mem_access = 1'b1; dmem_ready = 1'b0; #1;
    chk("mem2_detect", 32'(outs), 32'(O_STALL));
    @(negedge clk); dmem_ready = 1'b1; ex_branch_taken = 1'b1; #1;
    chk("mem2_release_br", 32'(outs), 32'(O_REL_BR));

    // Timeout: 4 MEM_WAIT cycles with ready low -> HALT.
    do_reset();
    mem_access = 1'b1; dmem_ready = 1'b0; #1;
    chk("to_detect", 32'(outs), 32'(O_STALL));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      chk("to_wait", 32'(outs), 32'(O_STALL));
      chk("to_err_low", 32'(err_timeout), 32'd0);
    end
    @(negedge clk); #1;
    chk("halt_outs", 32'(outs), 32'(O_ZERO));
    chk("halt_err", 32'(err_timeout), 32'd1);
    chk("halt_cnt", 32'(stall_cnt), 32'd5);
    @(negedge clk); dmem_ready = 1'b1; #1;
    chk("halt_stays", 32'(outs), 32'(O_ZERO));
    chk("halt_cnt2", 32'(stall_cnt), 32'd6);
    repeat (65540) @(negedge clk);
    #1;
    chk("cnt_saturate", 32'(stall_cnt), 32'hFFFF);
    #2 rst = 1'b0; #1;
    chk("halt_rst_err", 32'(err_timeout), 32'd0);
    chk("halt_rst_cnt", 32'(stall_cnt), 32'd0);
    @(negedge clk); idle(); rst = 1'b1; #1;
    chk("reinit_outs", 32'(outs), 32'(O_ZERO));
    @(negedge clk); #1;
    chk("rerun_idle", 32'(outs), 32'(O_IDLE));

    // Asynchronous reset mid-cycle in MEM_WAIT drops dmem_req at once.
    do_reset();
    mem_access = 1'b1; dmem_ready = 1'b0;
    @(negedge clk); #1;
    chk("abort_req_before", 32'(dmem_req), 32'd1);
    #2 rst = 1'b0; #1;
    chk("abort_outs", 32'(outs), 32'(O_ZERO));
    @(negedge clk); rst = 1'b1; idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
